median_filter: RTL and testbench



---
 rtl/median_filter.sv | 240 ++++++++++++++++++++++++
 tb/tb_median_filter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/median_filter.sv
// ============================================================================
// median_filter
// ----------------------------------------------------------------------------
// 3x3 median filter for a raster-order 8-bit luma stream. It sits between the
// YCbCr conversion and the edge detector and removes impulse noise before the
// gradient stage.
//
// Two line buffers hold the previous row (lb1) and the row two back (lb2).
// Both are addressed directly by hcount. On every edge the old contents are
// read, and the buffers are then updated in place:
//   - lb2[h] <= old lb1[h]
//   - lb1[h] <= Y
// The column {lb2[h], lb1[h], Y} is shifted into a 3-column window. A
// three-stage median network follows:
//   1. Sort each column into lo/mid/hi.
//   2. Compute max of the los, median of the mids, and min of the his.
//   3. Take the median of those three values.
// pixel_value therefore updates three edges after the window loads.
//
// Parameters:
//   LINE_LEN     line-buffer depth in pixels (default 1024). Samples with
//                hcount >= LINE_LEN do not write the buffers, and they read 0.
//
// Ports:
//   clk          pixel clock, rising-edge active
//   rst          asynchronous active-high reset (clears window, pipeline,
//                valid bits and output; line-buffer RAM is not cleared)
//   hcount       column of the pixel on Y (11 bits)
//   vcount       row of the pixel on Y (11 bits)
//   Y            8-bit luma sample at (hcount, vcount)
//   pixel_value  filtered pixel, registered
//
// Configuration macro:
//   MEDIAN_BORDER_PASS_EN  When defined, windows that are not fully inside the
//                          frame output the raw centre pixel instead of 0.
//                          Latency is the same either way.
// ============================================================================
module median_filter #(
    parameter int LINE_LEN = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [7:0]  Y,
    output logic [7:0]  pixel_value
);

    localparam int          ADDR_W     = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [11:0] LINE_LEN_W = 12'(LINE_LEN);

    // ------------------------------------------------------------------------
    // Small compare helpers. Ties fall through to a fixed operand, so equal
    // inputs always return that same value.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return min2(min2(a, b), c);
    endfunction

    // Median of three: clamp c between min(a,b) and max(a,b).
    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // ------------------------------------------------------------------------
    // Line buffers
    // ------------------------------------------------------------------------
    logic [7:0]        lb1_mem [LINE_LEN];
    logic [7:0]        lb2_mem [LINE_LEN];
    logic              in_range;
    logic [ADDR_W-1:0] lb_addr;
    logic [7:0]        lb1_rd;
    logic [7:0]        lb2_rd;

    assign in_range = ({1'b0, hcount} < LINE_LEN_W);
    assign lb_addr  = hcount[ADDR_W-1:0];

    // The read is combinational. The column for sample (h, v) must enter the
    // window on the same edge that samples it. Out-of-range columns read as
    // zero so that the window is still formed.
    always_comb begin
        lb1_rd = '0;
        lb2_rd = '0;
        if (in_range) begin
            lb1_rd = lb1_mem[lb_addr];
            lb2_rd = lb2_mem[lb_addr];
        end
    end

    // Read-before-write: lb2 takes the value that lb1 held before this edge.
    always_ff @(posedge clk) begin
        if (in_range) begin
            lb2_mem[lb_addr] <= lb1_rd;
            lb1_mem[lb_addr] <= Y;
        end
    end

    // ------------------------------------------------------------------------
    // Window: win_reg[col][row].
    //   - col 0 is the newest column (h), col 2 the oldest (h-2).
    //   - row 0 is the top (v-2), row 2 the bottom (v).
    // ------------------------------------------------------------------------
    logic [2:0][2:0][7:0] win_reg;
    logic [2:0][7:0]      new_col;
    logic                 win_valid_reg;
    logic                 win_valid_next;

    assign new_col        = {Y, lb1_rd, lb2_rd};
    assign win_valid_next = (hcount >= 11'd2) && (vcount >= 11'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_reg       <= '0;
            win_valid_reg <= 1'b0;
        end else begin
            win_reg       <= {win_reg[1], win_reg[0], new_col};
            win_valid_reg <= win_valid_next;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: per-column sort
    // ------------------------------------------------------------------------
    logic [2:0][7:0] col_lo_next;
    logic [2:0][7:0] col_mid_next;
    logic [2:0][7:0] col_hi_next;
    logic [2:0][7:0] col_lo_reg;
    logic [2:0][7:0] col_mid_reg;
    logic [2:0][7:0] col_hi_reg;
    logic            valid_s1_reg;

    for (genvar gi = 0; gi < 3; gi++) begin : g_col_sort
        assign col_lo_next[gi]  = min3(win_reg[gi][0], win_reg[gi][1], win_reg[gi][2]);
        assign col_mid_next[gi] = med3(win_reg[gi][0], win_reg[gi][1], win_reg[gi][2]);
        assign col_hi_next[gi]  = max3(win_reg[gi][0], win_reg[gi][1], win_reg[gi][2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_lo_reg   <= '0;
            col_mid_reg  <= '0;
            col_hi_reg   <= '0;
            valid_s1_reg <= 1'b0;
        end else begin
            col_lo_reg   <= col_lo_next;
            col_mid_reg  <= col_mid_next;
            col_hi_reg   <= col_hi_next;
            valid_s1_reg <= win_valid_reg;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: reduce the three sorted columns to three candidates
    // ------------------------------------------------------------------------
    logic [7:0] max_lo_next;
    logic [7:0] mid_mid_next;
    logic [7:0] min_hi_next;
    logic [7:0] max_lo_reg;
    logic [7:0] mid_mid_reg;
    logic [7:0] min_hi_reg;
    logic       valid_s2_reg;

    assign max_lo_next  = max3(col_lo_reg[0], col_lo_reg[1], col_lo_reg[2]);
    assign mid_mid_next = med3(col_mid_reg[0], col_mid_reg[1], col_mid_reg[2]);
    assign min_hi_next  = min3(col_hi_reg[0], col_hi_reg[1], col_hi_reg[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_lo_reg   <= '0;
            mid_mid_reg  <= '0;
            min_hi_reg   <= '0;
            valid_s2_reg <= 1'b0;
        end else begin
            max_lo_reg   <= max_lo_next;
            mid_mid_reg  <= mid_mid_next;
            min_hi_reg   <= min_hi_next;
            valid_s2_reg <= valid_s1_reg;
        end
    end

    // ------------------------------------------------------------------------
    // Border value: raw centre pixel (optional) or zero
    // ------------------------------------------------------------------------
    logic [7:0] border_value;

`ifdef MEDIAN_BORDER_PASS_EN
    // The centre pixel is the mid row of column 1 of the window that stage 1
    // is sorting. It is delayed alongside the median data so that it lines up
    // with the valid bit at the output.
    logic [7:0] center_s1_reg;
    logic [7:0] center_s2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            center_s1_reg <= '0;
            center_s2_reg <= '0;
        end else begin
            center_s1_reg <= win_reg[1][1];
            center_s2_reg <= center_s1_reg;
        end
    end

    assign border_value = center_s2_reg;
`else
    assign border_value = '0;
`endif

    // ------------------------------------------------------------------------
    // Stage 3: final median and output register
    // ------------------------------------------------------------------------
    logic [7:0] median_next;
    logic [7:0] pixel_next;

    assign median_next = med3(max_lo_reg, mid_mid_reg, min_hi_reg);
    assign pixel_next  = valid_s2_reg ? median_next : border_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_value <= '0;
        end else begin
            pixel_value <= pixel_next;
        end
    end

endmodule

// File: tb/tb_median_filter.sv
// ============================================================================
// tb_median_filter
// ----------------------------------------------------------------------------
// Directed bench for median_filter. Frames are streamed pixel by pixel, and
// each pixel carries a hand-derived expected output. That value is compared
// with pixel_value three edges later. The stimulus covers:
//   - reset state
//   - a ramp
//   - an impulse in a flat field
//   - a checkerboard
//   - a 50/50/100 row stack
//   - columns beyond LINE_LEN
//   - an asynchronous reset pulse mid-row
// Build with MEDIAN_BORDER_PASS_EN defined to exercise the border-pass
// variant.
// ============================================================================
module tb_median_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [7:0]  Y;
    logic [7:0]  pixel_value;

`ifdef MEDIAN_BORDER_PASS_EN
    localparam bit PASS = 1'b1;
`else
    localparam bit PASS = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Expected-value delay line: entry 2 is the sample from three edges ago.
    int exp_q   [3];
    bit chk_q   [3];
    int tag_h_q [3];
    int tag_v_q [3];

    median_filter #(.LINE_LEN(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .Y           (Y),
        .pixel_value (pixel_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Arm the delay line so that the next three outputs must be zero.
    task automatic expect_zero_pipe();
        for (int i = 0; i < 3; i++) begin
            chk_q[i]   = 1'b1;
            exp_q[i]   = 0;
            tag_h_q[i] = -1;
            tag_v_q[i] = -1;
        end
    endtask

    // Present one pixel, take one edge, then check the output that belongs
    // to the pixel sent three edges earlier.
    task automatic send(input int h, input int v, input int y, input bit chk, input int expv);
        hcount = 11'(h);
        vcount = 11'(v);
        Y      = 8'(y);
        @(posedge clk);
        #1;
        $display("pix h=%0d v=%0d y=%0d out=%0d", h, v, y, pixel_value);
        if (chk_q[2])
            check($sformatf("pix(%0d,%0d)", tag_h_q[2], tag_v_q[2]), pixel_value, 8'(exp_q[2]));
        for (int i = 2; i > 0; i--) begin
            chk_q[i]   = chk_q[i-1];
            exp_q[i]   = exp_q[i-1];
            tag_h_q[i] = tag_h_q[i-1];
            tag_v_q[i] = tag_v_q[i-1];
        end
        chk_q[0]   = chk;
        exp_q[0]   = expv;
        tag_h_q[0] = h;
        tag_v_q[0] = v;
    endtask

    // Choose the expectation for one pixel:
    //   - valid window: the hand-derived median (if vchk is set)
    //   - border, default build: 0
    //   - border, border-pass build: the centre pixel, checked only where
    //     the caller knows it (ck)
    task automatic frame_pix(input int h, input int v, input int y,
                             input bit vchk, input int vexp,
                             input bit ck, input int cexp);
        bit chk;
        int e;
        if (h >= 2 && v >= 2) begin
            chk = vchk;
            e   = vexp;
        end else if (PASS) begin
            chk = ck;
            e   = cexp;
        end else begin
            chk = 1'b1;
            e   = 0;
        end
        send(h, v, y, chk, e);
    endtask

    initial begin
        rst    = 1'b1;
        hcount = '0;
        vcount = '0;
        Y      = '0;
        for (int i = 0; i < 3; i++) begin
            chk_q[i]   = 1'b0;
            exp_q[i]   = 0;
            tag_h_q[i] = -1;
            tag_v_q[i] = -1;
        end

        // Reset state
        @(posedge clk); #1;
        check("rst_state0", pixel_value, 8'd0);
        @(posedge clk); #1;
        check("rst_state1", pixel_value, 8'd0);
        rst = 1'b0;
        expect_zero_pipe();

        // Ramp Y = h + v, 21 px/line, rows 0..10.
        //   - valid median = (h-1) + (v-1)
        //   - centre pixel at h=1 is Y(0, v-1) = v-1
        for (int v = 0; v <= 10; v++)
            for (int h = 0; h <= 20; h++)
                frame_pix(h, v, h + v, 1'b1, (h - 1) + (v - 1), (h == 1 && v >= 2), v - 1);

        // Flat 10 with one 255 impulse at (7,4): every valid window -> 10.
        for (int v = 0; v <= 6; v++)
            for (int h = 0; h <= 11; h++)
                frame_pix(h, v, (h == 7 && v == 4) ? 255 : 10, 1'b1, 10, (h == 1 && v >= 2), 10);

        // Checkerboard 0/200. The centre parity equals the parity of (h + v).
        // Five cells share the centre's value, so the median is the centre.
        for (int v = 0; v <= 4; v++)
            for (int h = 0; h <= 7; h++)
                frame_pix(h, v, ((h + v) % 2 == 1) ? 200 : 0, 1'b1,
                          ((h + v) % 2 == 1) ? 200 : 0,
                          (h == 1 && v >= 2), ((v - 1) % 2 == 1) ? 200 : 0);

        // Rows of 50, 50, 100, 100:
        //   - row 2 window (50, 50, 100) -> 50
        //   - row 3 window (50, 100, 100) -> 100
        for (int v = 0; v <= 3; v++)
            for (int h = 0; h <= 5; h++)
                frame_pix(h, v, (v < 2) ? 50 : 100, 1'b1, (v == 2) ? 50 : 100,
                          (h == 1 && v >= 2), (v - 1 < 2) ? 50 : 100);

        // Columns 1021..1026 of flat 80, rows 0..2. Columns >= 1024 read as
        // {0, 0, 80}. On row 2 this gives 80, 80, 80 at h = 1023..1025,
        // and 0 at h = 1026, where all three columns are out of range.
        for (int v = 0; v <= 2; v++)
            for (int h = 1021; h <= 1026; h++)
                frame_pix(h, v, 80, (h >= 1023), (h == 1026) ? 0 : 80, 1'b0, 0);

        // Ramp again, with an asynchronous reset pulse before (8,5). The
        // output clears at once and stays 0 for the three refill edges. The
        // two partial windows right after release are not checked.
        for (int v = 0; v <= 6; v++)
            for (int h = 0; h <= 20; h++) begin
                if (v == 5 && h == 8) begin
                    rst = 1'b1;
                    #1;
                    check("rst_async", pixel_value, 8'd0);
                    #1;
                    rst = 1'b0;
                    expect_zero_pipe();
                end
                frame_pix(h, v, h + v, !(v == 5 && (h == 8 || h == 9)),
                          (h - 1) + (v - 1), (h == 1 && v >= 2), v - 1);
            end

        // Flush the last three expectations.
        for (int i = 0; i < 3; i++)
            send(0, 0, 0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
